// File: rtl/mips_encode.sv
// mips_encode: encodes ALU-level requests into MIPS R/I-type words queued behind an output FIFO
module mips_encode #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  alu_op,
   input  logic [1:0]  alu_src2,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  dest,
   input  logic [15:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        except,
   output logic [15:0] enc_count,
   output logic [15:0] err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
   logic [5:0]    funct;
   logic [5:0]    imm_op;
   logic          legal;
   logic [31:0]   word;
   logic          s1_valid;
   logic          s1_legal;
   logic [31:0]   s1_word;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW+1:0] occupancy;
   logic          push;
   logic          pop;
   logic          accept;

   // request encoding: R-type funct, I-type opcode (0 marks an unencodable pair) and legality
   always_comb begin
      funct  = alu_op == 3'd0 ? 6'h21 : alu_op == 3'd2 ? 6'h20 : alu_op == 3'd3 ? 6'h22 :
               alu_op == 3'd4 ? 6'h24 : alu_op == 3'd5 ? 6'h25 : alu_op == 3'd6 ? 6'h27 : 6'h26;
      imm_op = alu_src2 == 2'b01 ? (alu_op == 3'd2 ? 6'h08 : alu_op == 3'd0 ? 6'h09 : 6'h00) :
               alu_src2 == 2'b10 ? (alu_op == 3'd4 ? 6'h0C : alu_op == 3'd5 ? 6'h0D :
                                    alu_op == 3'd7 ? 6'h0E : 6'h00) : 6'h00;
      legal  = alu_src2 == 2'b00 ? alu_op != 3'd1 : imm_op != 6'h00;
      word   = alu_src2 == 2'b00 ? {6'h00, rs, rt, dest, 5'h00, funct} : {imm_op, rs, dest, imm};
   end

   assign push      = s1_valid & s1_legal;
   assign pop       = out_valid & out_ready;
   assign occupancy = {1'b0, count} + (AW+2)'(push);
   assign in_ready  = ~reset & (occupancy < DEPTH_W);
   assign accept    = in_valid & in_ready;
   assign out_valid = count != '0;
   assign out_word  = out_valid ? mem[rd_ptr] : 32'h0;
   assign except    = s1_valid & ~s1_legal;

   // S1 stage: holds the accepted request and its legality for one cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_legal <= 1'b0;
         s1_word  <= 32'h0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_legal <= legal;
            s1_word  <= word;
         end
      end
   end

   // FIFO storage: a legal S1 entry is written at the tail
   always_ff @(posedge clock) begin
      if (push & ~reset) mem[wr_ptr] <= s1_word;
   end

   // FIFO pointers and count; occupancy-based in_ready keeps a push off a full FIFO
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // saturating counters of encoded and dropped requests
   always_ff @(posedge clock) begin
      if (reset) begin
         enc_count <= 16'h0;
         err_count <= 16'h0;
      end else begin
         enc_count <= enc_count + 16'(push & (enc_count != 16'hFFFF));
         err_count <= err_count + 16'(except & (err_count != 16'hFFFF));
      end
   end
endmodule

// File: tb/tb_mips_encode.sv
// tb_mips_encode: randomized and directed checks of mips_encode against a queue-based model
module tb_mips_encode;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  alu_op = 3'd0;
   logic [1:0]  alu_src2 = 2'd0;
   logic [4:0]  rs = 5'd0;
   logic [4:0]  rt = 5'd0;
   logic [4:0]  dest = 5'd0;
   logic [15:0] imm = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic        except;
   logic [15:0] enc_count;
   logic [15:0] err_count;

   int n_tests = 0;
   int n_fail = 0;

   mips_encode #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .alu_src2(alu_src2), .rs(rs), .rt(rt), .dest(dest), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .except(except),
      .enc_count(enc_count), .err_count(err_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference encoding straight from the opcode/funct tables; bit 32 is legality
   function automatic logic [32:0] menc(input logic [2:0] op, input logic [1:0] s, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] d, input logic [15:0] im);
      logic [5:0] f;
      case (op)
         3'd0: f = 6'h21;
         3'd2: f = 6'h20;
         3'd3: f = 6'h22;
         3'd4: f = 6'h24;
         3'd5: f = 6'h25;
         3'd6: f = 6'h27;
         3'd7: f = 6'h26;
         default: f = 6'h00;
      endcase
      if (s == 2'd0) return (op == 3'd1) ? 33'h0 : {1'b1, 6'h00, a, b, d, 5'h00, f};
      if (s == 2'd1 && op == 3'd2) return {1'b1, 6'h08, a, d, im};
      if (s == 2'd1 && op == 3'd0) return {1'b1, 6'h09, a, d, im};
      if (s == 2'd2 && op == 3'd4) return {1'b1, 6'h0C, a, d, im};
      if (s == 2'd2 && op == 3'd5) return {1'b1, 6'h0D, a, d, im};
      if (s == 2'd2 && op == 3'd7) return {1'b1, 6'h0E, a, d, im};
      return 33'h0;
   endfunction

   bit          armed = 0;
   bit          m_s1v = 0;
   bit          m_s1l = 0;
   logic [31:0] m_s1w = 32'h0;
   logic [31:0] q[$];
   int          m_enc = 0;
   int          m_err = 0;

   always @(posedge clock) begin : model
      bit acc;
      logic [32:0] r;
      if (reset) begin
         armed = 1;
         m_s1v = 0;
         m_s1l = 0;
         q.delete();
         m_enc = 0;
         m_err = 0;
      end else if (armed) begin
         acc = in_valid && (q.size() + ((m_s1v && m_s1l) ? 1 : 0) < 4);
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (m_s1v && m_s1l) begin
            q.push_back(m_s1w);
            if (m_enc < 65535) m_enc++;
         end
         if (m_s1v && !m_s1l && m_err < 65535) m_err++;
         r = menc(alu_op, alu_src2, rs, rt, dest, imm);
         m_s1v = acc;
         m_s1l = r[32];
         m_s1w = r[31:0];
      end
   end

   always @(negedge clock) begin : compare
      int occ;
      if (armed) begin
         occ = q.size() + ((m_s1v && m_s1l) ? 1 : 0);
         check("in_ready", 32'(in_ready), 32'(!reset && occ < 4));
         check("out_valid", 32'(out_valid), 32'(q.size() > 0));
         check("out_word", out_word, q.size() > 0 ? q[0] : 32'h0);
         check("except", 32'(except), 32'(m_s1v && !m_s1l));
         check("enc_count", 32'(enc_count), 32'(m_enc));
         check("err_count", 32'(err_count), 32'(m_err));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] s, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic [15:0] im);
      int n;
      n = 0;
      in_valid = 1'b1;
      alu_op = op;
      alu_src2 = s;
      rs = a;
      rt = b;
      dest = d;
      imm = im;
      while (!in_ready && n < 20) begin
         step(1);
         n++;
      end
      check("accept", 32'(in_ready), 32'd1);
      step(1);
   endtask

   initial begin
      int acc;
      int n;
      step(2);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_word", out_word, 32'h0);
      check("rst_enc", 32'(enc_count), 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      send(3'd2, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0);
      in_valid = 1'b0;
      step(1);
      check("add_r_word", out_word, 32'h00221820);
      check("add_r_valid", 32'(out_valid), 32'd1);
      check("add_r_enc", 32'(enc_count), 32'd1);
      check("add_r_except", 32'(except), 32'd0);
      step(1);
      out_ready = 1'b0;
      send(3'd2, 2'd1, 5'd4, 5'd9, 5'd5, 16'hFFFF);
      send(3'd5, 2'd2, 5'd0, 5'd9, 5'd8, 16'h1234);
      in_valid = 1'b0;
      step(1);
      check("addi_word", out_word, 32'h2085FFFF);
      out_ready = 1'b1;
      step(1);
      check("ori_word", out_word, 32'h34081234);
      step(1);
      check("drained", 32'(out_valid), 32'd0);
      send(3'd3, 2'd1, 5'd1, 5'd1, 5'd1, 16'h1);
      in_valid = 1'b0;
      check("ill_sub_imm", 32'(except), 32'd1);
      step(1);
      check("ill_pulse_end", 32'(except), 32'd0);
      send(3'd1, 2'd0, 5'd1, 5'd1, 5'd1, 16'h1);
      in_valid = 1'b0;
      check("ill_op1", 32'(except), 32'd1);
      step(1);
      send(3'd2, 2'd3, 5'd1, 5'd1, 5'd1, 16'h1);
      in_valid = 1'b0;
      check("ill_src3", 32'(except), 32'd1);
      step(1);
      check("ill_err", 32'(err_count), 32'd3);
      check("ill_enc", 32'(enc_count), 32'd3);
      check("ill_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = acc < 6;
         alu_op = 3'd4;
         alu_src2 = 2'd0;
         rs = 5'(acc);
         rt = 5'd7;
         dest = 5'(acc + 10);
         if (in_valid && in_ready) acc++;
         step(1);
      end
      check("bp_accepted", 32'(acc), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      n = 0;
      while (acc < 6 && n < 20) begin
         rs = 5'(acc);
         dest = 5'(acc + 10);
         if (in_ready) acc++;
         step(1);
         n++;
      end
      in_valid = 1'b0;
      check("bp_rest", 32'(acc), 32'd6);
      step(6);
      check("bp_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(3'd7, 2'd2, 5'(i), 5'd0, 5'd1, 16'(i));
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      step(1);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_enc", 32'(enc_count), 32'd0);
      check("mid_rst_err", 32'(err_count), 32'd0);
      check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step(3);
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3000; i++) begin
         reset = $urandom_range(0, 199) == 0;
         in_valid = $urandom_range(0, 3) != 0;
         alu_op = 3'($urandom_range(0, 7));
         alu_src2 = 2'($urandom_range(0, 3));
         rs = 5'($urandom);
         rt = 5'($urandom);
         dest = 5'($urandom);
         imm = 16'($urandom);
         out_ready = $urandom_range(0, 2) != 0;
         step(1);
      end
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step(8);
      in_valid = 1'b1;
      alu_op = 3'd0;
      alu_src2 = 2'd1;
      for (int i = 0; i < 65540; i++) begin
         imm = 16'(i);
         step(1);
      end
      in_valid = 1'b0;
      step(3);
      check("sat_enc", 32'(enc_count), 32'h0000FFFF);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
